// File: rtl/Purple_Jade.sv
// Shared Purple_Jade core parameters used across front-end and back-end blocks.
package Purple_Jade;

   localparam int WORD_SIZE_P               = 32;
   localparam int DECODED_INSTRUCTION_WIDTH = 2 * WORD_SIZE_P;

endpackage : Purple_Jade

// File: rtl/fe_be_queue_chk.sv
// Simulation-only protocol checks for fe_be_queue, attached by bind.
// Flags a consume request from the back end while the queue shows nothing valid.
module fe_be_queue_chk (
   input logic clk_i,
   input logic reset_i,
   input logic yumi_i,
   input logic v_o
);

   yumi_without_valid_a : assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
      else $error("fe_be_queue: yumi_i asserted while v_o=0");

endmodule : fe_be_queue_chk

bind fe_be_queue fe_be_queue_chk u_fe_be_queue_chk (.*);

// File: rtl/fe_be_queue_mem.sv
// Storage for the front-end to back-end queue.
// 1-read 1-write register array: synchronous write, asynchronous read, no reset on contents.
module fe_be_queue_mem #(
   parameter int width_p = 8,
   parameter int els_p   = 32
) (
   input  logic                       clk_i,
   input  logic                       w_v_i,
   input  logic [$clog2(els_p)-1:0]   w_addr_i,
   input  logic [width_p-1:0]         w_data_i,
   input  logic [$clog2(els_p)-1:0]   r_addr_i,
   output logic [width_p-1:0]         r_data_o
);

   logic [width_p-1:0] mem_q [els_p];

   // Write port: capture the incoming entry at the write address.
   always_ff @(posedge clk_i) begin
      if (w_v_i) begin
         mem_q[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem_q[r_addr_i];

endmodule : fe_be_queue_mem

// File: rtl/fe_be_queue.sv
// Front-end to back-end decoded-instruction queue: circular buffer with
// read/write pointers and an occupancy counter; flush empties it in one cycle.
module fe_be_queue
   import Purple_Jade::*;
#(
   parameter int width_p = DECODED_INSTRUCTION_WIDTH,
   parameter int els_p   = 32
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       flush_i,
   input  logic                       v_i,
   input  logic [width_p-1:0]         data_i,
   output logic                       ready_o,
   output logic                       v_o,
   output logic [width_p-1:0]         data_o,
   input  logic                       yumi_i,
   output logic [$clog2(els_p):0]     count_o
);

   localparam int ptr_w_lp = $clog2(els_p);
   localparam int cnt_w_lp = ptr_w_lp + 1;
   localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                enq_s, deq_s;

   // Status depends only on stored occupancy, never on yumi_i.
   assign ready_o = (count_q != full_cnt_lp);
   assign v_o     = (count_q != {cnt_w_lp{1'b0}});
   assign count_o = count_q;

   assign enq_s = v_i & ready_o & ~flush_i;
   assign deq_s = yumi_i & v_o & ~flush_i;

   // Next-state pointers and occupancy; flush wins over any transfer.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = {ptr_w_lp{1'b0}};
         wr_ptr_d = {ptr_w_lp{1'b0}};
         count_d  = {cnt_w_lp{1'b0}};
      end else begin
         if (enq_s) begin
            wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (deq_s) begin
            rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({enq_s, deq_s})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared immediately by reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_q <= {ptr_w_lp{1'b0}};
         wr_ptr_q <= {ptr_w_lp{1'b0}};
         count_q  <= {cnt_w_lp{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   fe_be_queue_mem #(
      .width_p (width_p),
      .els_p   (els_p)
   ) u_mem (
      .clk_i    (clk_i),
      .w_v_i    (enq_s),
      .w_addr_i (wr_ptr_q),
      .w_data_i (data_i),
      .r_addr_i (rd_ptr_q),
      .r_data_o (data_o)
   );

endmodule : fe_be_queue

// File: tb/tb_fe_be_queue.sv
// Directed self-checking bench for fe_be_queue with hand-computed expectations.
module tb_fe_be_queue;
   import Purple_Jade::*;

   localparam int W_LP   = DECODED_INSTRUCTION_WIDTH;
   localparam int ELS_LP = 32;

   logic                      clk_i = 1'b0;
   logic                      reset_i;
   logic                      flush_i;
   logic                      v_i;
   logic [W_LP-1:0]           data_i;
   logic                      ready_o;
   logic                      v_o;
   logic [W_LP-1:0]           data_o;
   logic                      yumi_i;
   logic [$clog2(ELS_LP):0]   count_o;

   int checks_total  = 0;
   int checks_passed = 0;

   fe_be_queue #(.width_p(W_LP), .els_p(ELS_LP)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .v_i     (v_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .v_o     (v_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i),
      .count_o (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_total++;
      if (got === exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      flush_i = 1'b0;
      v_i     = 1'b0;
      yumi_i  = 1'b0;
      data_i  = '0;
   endtask

   initial begin
      int enq_idx;
      int deq_idx;
      int mc;
      logic do_v;
      logic do_y;

      reset_i = 1'b1;
      idle_inputs();
      #2;
      check_eq("rst_count", 64'(count_o), 64'd0);
      check_eq("rst_v", 64'(v_o), 64'd0);
      check_eq("rst_ready", 64'(ready_o), 64'd1);
      step();
      step();
      reset_i = 1'b0;

      // Fill from reset with 0..31, then offer 32 while full.
      for (int i = 0; i < ELS_LP; i++) begin
         v_i = 1'b1;
         data_i = W_LP'(i);
         step();
         if (i == 0) begin
            check_eq("fill_first_v", 64'(v_o), 64'd1);
            check_eq("fill_first_data", 64'(data_o), 64'd0);
         end
      end
      check_eq("fill_count", 64'(count_o), 64'd32);
      check_eq("fill_ready", 64'(ready_o), 64'd0);
      data_i = W_LP'(32);
      step();
      check_eq("full_reject_count", 64'(count_o), 64'd32);
      check_eq("full_reject_head", 64'(data_o), 64'd0);
      v_i = 1'b0;

      // Drain in order.
      for (int i = 0; i < ELS_LP; i++) begin
         check_eq("drain_data", 64'(data_o), 64'(i));
         yumi_i = 1'b1;
         step();
      end
      yumi_i = 1'b0;
      check_eq("drain_v", 64'(v_o), 64'd0);
      check_eq("drain_count", 64'(count_o), 64'd0);
      check_eq("drain_ready", 64'(ready_o), 64'd1);

      // Wrap-around: 48 enqueues with occupancy held at 3..5.
      enq_idx = 0;
      deq_idx = 0;
      mc = 0;
      for (int c = 0; c < 80; c++) begin
         do_v = (enq_idx < 48);
         do_y = (mc >= 4) || (enq_idx >= 48 && mc > 0);
         if (do_y) begin
            check_eq("wrap_data", 64'(data_o), 64'(100 + deq_idx));
         end
         v_i = do_v;
         data_i = W_LP'(100 + enq_idx);
         yumi_i = do_y;
         step();
         if (do_v) begin
            enq_idx++;
            mc++;
         end
         if (do_y) begin
            deq_idx++;
            mc--;
         end
      end
      idle_inputs();
      check_eq("wrap_end_count", 64'(count_o), 64'd0);
      check_eq("wrap_end_v", 64'(v_o), 64'd0);

      // Flush priority with count 7 and simultaneous v_i/yumi_i.
      for (int i = 0; i < 7; i++) begin
         v_i = 1'b1;
         data_i = W_LP'(200 + i);
         step();
      end
      check_eq("pre_flush_count", 64'(count_o), 64'd7);
      flush_i = 1'b1;
      v_i = 1'b1;
      yumi_i = 1'b1;
      data_i = W_LP'(64'h77);
      step();
      idle_inputs();
      check_eq("flush_count", 64'(count_o), 64'd0);
      check_eq("flush_v", 64'(v_o), 64'd0);
      v_i = 1'b1;
      data_i = W_LP'(64'hA5);
      step();
      v_i = 1'b0;
      check_eq("post_flush_v", 64'(v_o), 64'd1);
      check_eq("post_flush_data", 64'(data_o), 64'hA5);
      check_eq("post_flush_count", 64'(count_o), 64'd1);
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
      flush_i = 1'b1;
      v_i = 1'b1;
      step();
      idle_inputs();
      check_eq("flush_empty_count", 64'(count_o), 64'd0);

      // Full with simultaneous consume: incoming entry rejected, accepted next cycle.
      for (int i = 0; i < ELS_LP; i++) begin
         v_i = 1'b1;
         data_i = W_LP'(300 + i);
         step();
      end
      check_eq("full2_count", 64'(count_o), 64'd32);
      v_i = 1'b1;
      yumi_i = 1'b1;
      data_i = W_LP'(64'h55);
      step();
      yumi_i = 1'b0;
      check_eq("full_consume_count", 64'(count_o), 64'd31);
      check_eq("full_consume_ready", 64'(ready_o), 64'd1);
      check_eq("full_consume_head", 64'(data_o), 64'd301);
      step();
      v_i = 1'b0;
      check_eq("full_retry_count", 64'(count_o), 64'd32);
      for (int i = 0; i < ELS_LP; i++) begin
         check_eq("full_drain_data", 64'(data_o), (i < 31) ? 64'(301 + i) : 64'h55);
         yumi_i = 1'b1;
         step();
      end
      yumi_i = 1'b0;
      check_eq("full_drain_count", 64'(count_o), 64'd0);

      // Async reset mid-stream with 10 entries.
      for (int i = 0; i < 10; i++) begin
         v_i = 1'b1;
         data_i = W_LP'(400 + i);
         step();
      end
      v_i = 1'b0;
      check_eq("pre_reset_count", 64'(count_o), 64'd10);
      #2;
      reset_i = 1'b1;
      #1;
      check_eq("async_rst_v", 64'(v_o), 64'd0);
      check_eq("async_rst_count", 64'(count_o), 64'd0);
      check_eq("async_rst_ready", 64'(ready_o), 64'd1);
      step();
      reset_i = 1'b0;
      v_i = 1'b1;
      data_i = W_LP'(64'h1);
      step();
      v_i = 1'b0;
      check_eq("post_rst_v", 64'(v_o), 64'd1);
      check_eq("post_rst_data", 64'(data_o), 64'h1);
      check_eq("post_rst_count", 64'(count_o), 64'd1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule : tb_fe_be_queue

// File: doc/fe_be_queue.md
FE_BE_QUEUE -- requirements
Module: fe_be_queue

Interface
REQ-001 Parameter: width_p, default DECODED_INSTRUCTION_WIDTH, width of one decoded-instruction entry.
REQ-002 Parameter: els_p, default 32, entry count; power of two, at least 2.
REQ-003 Port: clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset_i  input  1  reset; asynchronous, active-high.
REQ-005 Port: flush_i  input  1  mispredict flush from the back end.
REQ-006 Port: v_i  input  1  front-end entry valid.
REQ-007 Port: data_i  input  width_p  front-end decoded instruction.
REQ-008 Port: ready_o  output  1  queue can accept an entry this cycle.
REQ-009 Port: v_o  output  1  head entry valid for the back end.
REQ-010 Port: data_o  output  width_p  head entry.
REQ-011 Port: yumi_i  input  1  back end consumes the head this cycle; legal only while v_o=1.
REQ-012 Port: count_o  output  $clog2(els_p)+1  current occupancy, 0..els_p.

Function
REQ-013 The block SHALL be a circular buffer with read pointer, write pointer and occupancy counter.
- Pointers are $clog2(els_p) bits wide.
- Pointers wrap from els_p-1 to 0.
REQ-014 ready_o SHALL equal (count_o != els_p) and SHALL NOT depend on yumi_i.
- No enqueue while full, even in a cycle with a simultaneous dequeue.
REQ-015 An enqueue SHALL occur when v_i & ready_o & ~flush_i:
- data_i is written at the write pointer;
- the write pointer increments.
REQ-016 A dequeue SHALL occur when yumi_i & v_o & ~flush_i; the read pointer increments.
REQ-017 v_o SHALL equal (count_o != 0), and data_o SHALL be the entry at the read pointer.
- data_o comes from storage only; there is no combinational path from data_i.
REQ-018 Enqueue-to-visible latency SHALL be 1 cycle: an entry written into an empty queue at edge N gives v_o=1 after edge N.
REQ-019 Simultaneous enqueue and dequeue SHALL leave count_o unchanged and advance both pointers.
REQ-020 Counter update SHALL be: count_o += enqueue; count_o -= dequeue.
REQ-021 flush_i=1 at an edge SHALL set both pointers and count_o to 0.
- That cycle's enqueue and dequeue are discarded.
- v_o=0 in the following cycle.
REQ-022 flush_i SHALL take priority over v_i and yumi_i in every state, including full and empty.
REQ-023 yumi_i while v_o=0 SHALL be ignored, with no state change; a simulation assertion SHALL flag it.
REQ-024 v_i while ready_o=0 SHALL be ignored; the producer holds the entry.
REQ-025 Storage contents SHALL NOT require reset.
- data_o is don't-care while v_o=0.

Reset
REQ-026 Assertion of reset_i SHALL immediately, without waiting for a clock edge, force:
- both pointers to 0 and count_o to 0;
- v_o=0 and ready_o=1.
REQ-027 Reset mid-operation SHALL discard all entries; after reset deasserts, the first accepted entry is the first entry presented.
REQ-028 Deassertion of reset_i SHALL be synchronous to clk_i; sequencing it is the top level's responsibility.

Structure
REQ-029 DECODED_INSTRUCTION_WIDTH and WORD_SIZE_P SHALL come from the shared Purple_Jade package; the block declares no local copies.
REQ-030 One sub-module, fe_be_queue_mem, SHALL hold the storage.
- It is a 1-read 1-write register array with synchronous write and asynchronous read.
- It takes width_p and els_p as parameters.
REQ-031 The top level SHALL drive flush_i from the back-end mispredict signal and SHALL NOT OR the mispredict into reset_i.

Verification
REQ-032 Fill from reset: v_i=1 for 32 cycles, yumi_i=0, data 0..31 -> ready_o=0 and count_o=32 after the 32nd edge; the 33rd value (32) is not accepted.
REQ-033 Drain in order: from full, yumi_i=1 for 32 cycles -> data_o sequence 0..31, v_o=0 and count_o=0 afterwards.
REQ-034 Wrap-around: 48 enqueues with interleaved dequeues, occupancy held at 3..5 -> dequeued order equals enqueued order across the pointer wrap, with no loss or duplicate.
REQ-035 Flush priority: count_o=7, then flush_i=1 with v_i=1 and yumi_i=1 in the same cycle -> count_o=0 and v_o=0 next cycle; the next enqueue (0xA5) appears as data_o one cycle later.
REQ-036 Full with simultaneous consume: count_o=32, v_i=1 and yumi_i=1 -> count_o=31 and the incoming entry is rejected; the following cycle accepts it and count_o=32.
REQ-037 Async reset mid-stream: reset_i asserted between edges with count_o=10 -> v_o=0 and count_o=0 before the next edge; after release, enqueuing 0x1 gives data_o=0x1.
